// File: rtl/ir_scan_ctrl.sv
// rtl/ir_scan_ctrl.sv - IR line-sensor scanner: emitter timing, A2D sequencing, averaging, max and line detect
module ir_scan_ctrl #(
    parameter int          NUM_CH    = 8,
    parameter int          CH_W      = 3,
    parameter int          PERIOD_W  = 18,
    parameter int          SETTLE_W  = 12,
    parameter int          AVG_SHIFT = 0,
    parameter logic [11:0] THR_HI    = 12'h048,
    parameter logic [11:0] THR_LO    = 12'h038
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cnv_cmplt,
    input  logic [11:0]          res,
    output logic                 strt_cnv,
    output logic [CH_W-1:0]      chnnl,
    output logic                 IR_en,
    output logic [NUM_CH*12-1:0] IR_vals,
    output logic                 IR_vld,
    output logic [11:0]          IR_max,
    output logic [CH_W-1:0]      max_idx,
    output logic                 line_present
);

    localparam int TMR_W = (PERIOD_W > SETTLE_W) ? PERIOD_W : SETTLE_W;
    localparam int CNT_W = AVG_SHIFT + 1;
    localparam int ACC_W = 12 + AVG_SHIFT;

    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'({PERIOD_W{1'b1}});
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'({SETTLE_W{1'b1}});
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << AVG_SHIFT) - 1);
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_TMR, SETTLE, START_CNV, WAIT_CNV, DONE
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [11:0]      run_max;
    logic [CH_W-1:0]  run_idx;

    logic [ACC_W-1:0] sum;
    logic [11:0]      avg;

    // Sum is never wider than ACC_W: 2^AVG_SHIFT samples of at most 12'hFFF.
    assign sum = acc + ACC_W'(res);
    assign avg = 12'(sum >> AVG_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tmr          <= '0;
            cnt          <= '0;
            acc          <= '0;
            run_max      <= '0;
            run_idx      <= '0;
            strt_cnv     <= 1'b0;
            chnnl        <= '0;
            IR_en        <= 1'b0;
            IR_vals      <= '0;
            IR_vld       <= 1'b0;
            IR_max       <= '0;
            max_idx      <= '0;
            line_present <= 1'b0;
        end else begin
            strt_cnv <= 1'b0;
            IR_vld   <= 1'b0;
            if (!en) begin
                // Abort: published max/flag stay as they were, slots already written stay too.
                state   <= IDLE;
                IR_en   <= 1'b0;
                tmr     <= '0;
                cnt     <= '0;
                acc     <= '0;
                run_max <= '0;
                run_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tmr     <= '0;
                        cnt     <= '0;
                        acc     <= '0;
                        run_max <= '0;
                        run_idx <= '0;
                        state   <= WAIT_TMR;
                    end
                    WAIT_TMR: begin
                        if (tmr == PERIOD_LAST) begin
                            tmr   <= '0;
                            IR_en <= 1'b1;
                            state <= SETTLE;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (tmr == SETTLE_LAST) begin
                            tmr   <= '0;
                            chnnl <= '0;
                            state <= START_CNV;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    START_CNV: begin
                        strt_cnv <= 1'b1;
                        state    <= WAIT_CNV;
                    end
                    WAIT_CNV: begin
                        if (cnv_cmplt) begin
                            if (cnt != CNT_LAST) begin
                                acc   <= sum;
                                cnt   <= cnt + CNT_W'(1);
                                state <= START_CNV;
                            end else begin
                                IR_vals[int'(chnnl)*12 +: 12] <= avg;
                                // Strict compare so a tie keeps the lower channel index.
                                if (avg > run_max) begin
                                    run_max <= avg;
                                    run_idx <= chnnl;
                                end
                                acc <= '0;
                                cnt <= '0;
                                if (chnnl == CH_LAST) begin
                                    IR_en <= 1'b0;
                                    state <= DONE;
                                end else begin
                                    chnnl <= chnnl + CH_W'(1);
                                    state <= START_CNV;
                                end
                            end
                        end
                    end
                    DONE: begin
                        IR_vld  <= 1'b1;
                        IR_max  <= run_max;
                        max_idx <= run_idx;
                        if (run_max > THR_HI)
                            line_present <= 1'b1;
                        else if (run_max < THR_LO)
                            line_present <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
